mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from EXE, waits for load data,
// extends the selected byte or halfword, and hands the result to WB with forwarding to decode.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [4:0]  ms_to_ds_dest,
    output logic [31:0] ms_to_ds_value,
    output logic        ms_to_ds_stall
);

    typedef enum logic [0:0] {StReady, StWait} state_e;

    state_e      state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic [75:0] bus_q, bus_d;
    logic [31:0] hold_q, hold_d;

    logic        ms_ready_go;
    logic        es_is_load;
    logic        data_take;

    logic        ld_b, ld_h, ld_w, ld_bu, ld_hu;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ld_b         = bus_q[75];
    assign ld_h         = bus_q[74];
    assign ld_w         = bus_q[73];
    assign ld_bu        = bus_q[72];
    assign ld_hu        = bus_q[71];
    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    assign es_is_load = es_to_ms_bus[70];
    assign ms_allowin = !ms_valid_q || (ms_ready_go && ws_allowin);

    // Only a held load still waiting may consume a data_ok pulse; anything else is stale.
    assign data_take = ms_valid_q && (state_q == StWait) && data_sram_data_ok;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StReady;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a newly accepted load waits, everything else is ready at once.
    always_comb begin
        state_d = state_q;
        if (ms_allowin) begin
            state_d = (es_to_ms_valid && es_is_load) ? StWait : StReady;
        end else if (data_take) begin
            state_d = StReady;
        end
    end

    // FSM outputs.
    always_comb begin
        ms_ready_go    = (state_q == StReady);
        ms_to_ds_stall = ms_valid_q && (state_q == StWait);
    end

    always_comb begin
        ms_valid_d = ms_valid_q;
        hold_d     = hold_q;
        bus_d      = bus_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_to_ms_bus;
        end
        if (data_take) begin
            hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            hold_q     <= 32'h0;
        end else begin
            ms_valid_q <= ms_valid_d;
            hold_q     <= hold_d;
        end
    end

    // Contents are don't-care while ms_valid_q is low, so no reset is needed.
    always_ff @(posedge clk) begin
        bus_q <= bus_d;
    end

    always_comb begin
        unique case (alu_result[1:0])
            2'b00:   load_byte = hold_q[7:0];
            2'b01:   load_byte = hold_q[15:8];
            2'b10:   load_byte = hold_q[23:16];
            default: load_byte = hold_q[31:24];
        endcase
        load_half = alu_result[1] ? hold_q[31:16] : hold_q[15:0];

        if (ld_b) begin
            load_data = {{24{load_byte[7]}}, load_byte};
        end else if (ld_bu) begin
            load_data = {24'h0, load_byte};
        end else if (ld_h) begin
            load_data = {{16{load_half[15]}}, load_half};
        end else if (ld_hu) begin
            load_data = {16'h0, load_half};
        end else if (ld_w) begin
            load_data = hold_q;
        end else begin
            load_data = hold_q;
        end

        final_result = res_from_mem ? load_data : alu_result;
    end

    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_to_ds_dest  = (ms_valid_q && gr_we) ? dest : 5'd0;
    assign ms_to_ds_value = (ms_to_ds_dest != 5'd0) ? final_result : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks with inline checks plus a
// scoreboard that compares every WB handoff against the expected instruction order.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ws_allowin = 1'b0;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [75:0] es_to_ms_bus = '0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_value;
    logic        ms_to_ds_stall;

    int total = 0;
    int bad = 0;
    logic [69:0] exp_q[$];

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_dest     (ms_to_ds_dest),
        .ms_to_ds_value    (ms_to_ds_value),
        .ms_to_ds_stall    (ms_to_ds_stall)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] LdB  = 5'b10000;
    localparam logic [4:0] LdH  = 5'b01000;
    localparam logic [4:0] LdW  = 5'b00100;
    localparam logic [4:0] LdBu = 5'b00010;
    localparam logic [4:0] LdHu = 5'b00001;

    function automatic logic [75:0] mk_bus(input logic [4:0] ld, input logic rfm,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {ld, rfm, we, dest, alu, pc};
    endfunction

    // Scoreboard: a handoff happens on the next rising edge whenever valid and allowin meet.
    always @(negedge clk) begin
        logic [69:0] exp;
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got bus=%h, required no handoff", ms_to_ws_bus);
            end else begin
                exp = exp_q.pop_front();
                if (ms_to_ws_bus !== exp) begin
                    bad++;
                    $display("FAIL sb_order: got bus=%h, required %h", ms_to_ws_bus, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        total++;
        if (ms_allowin !== 1'b1) begin
            bad++; $display("FAIL reset_allowin: got %b, required 1", ms_allowin);
        end
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b, required 0", ms_to_ws_valid);
        end
        total++;
        if ({ms_to_ds_dest, ms_to_ds_value, ms_to_ds_stall} !== 38'h0) begin
            bad++;
            $display("FAIL reset_fwd: got dest=%0d value=%h stall=%b, required all 0",
                     ms_to_ds_dest, ms_to_ds_value, ms_to_ds_stall);
        end
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        step();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(5'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h100);
        exp_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h100});
        step();
        es_to_ms_valid = 1'b0;
        mid();
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL alu_out: got valid=%b result=%h, required 1 12345678",
                     ms_to_ws_valid, ms_to_ws_bus[63:32]);
        end
        total++;
        if (ms_to_ds_dest !== 5'd5 || ms_to_ds_value !== 32'h1234_5678 || ms_to_ds_stall !== 1'b0)
        begin
            bad++;
            $display("FAIL alu_fwd: got dest=%0d value=%h stall=%b, required 5 12345678 0",
                     ms_to_ds_dest, ms_to_ds_value, ms_to_ds_stall);
        end
        step();
        mid();
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++; $display("FAIL alu_drain: got valid=%b, required 0", ms_to_ws_valid);
        end
    endtask

    task automatic do_load(input string name, input logic [4:0] ld, input logic [31:0] addr,
                           input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp_res, input logic [4:0] dest,
                           input logic [31:0] pc);
        step();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(ld, 1'b1, 1'b1, dest, addr, pc);
        exp_q.push_back({1'b1, dest, exp_res, pc});
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = rdata;
            end
            mid();
            total++;
            if (ms_to_ds_stall !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_wait: cycle %0d got stall=%b valid=%b, required 1 0",
                         name, i, ms_to_ds_stall, ms_to_ws_valid);
            end
            step();
        end
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        mid();
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ds_stall !== 1'b0 || ms_to_ds_value !== exp_res)
        begin
            bad++;
            $display("FAIL %s_result: got valid=%b stall=%b value=%h, required 1 0 %h",
                     name, ms_to_ws_valid, ms_to_ds_stall, ms_to_ds_value, exp_res);
        end
        step();
    endtask

    task automatic test_loads();
        do_load("ld_b",  LdB,  32'h0000_1003, 32'h80FF_0000, 2, 32'hFFFF_FF80, 5'd7,  32'h200);
        do_load("ld_hu", LdHu, 32'h0000_2002, 32'h8001_1234, 0, 32'h0000_8001, 5'd8,  32'h204);
        do_load("ld_h",  LdH,  32'h0000_2002, 32'h8001_1234, 1, 32'hFFFF_8001, 5'd8,  32'h208);
        do_load("ld_bu", LdBu, 32'h0000_3001, 32'h0000_AB00, 0, 32'h0000_00AB, 5'd11, 32'h20C);
        do_load("ld_w",  LdW,  32'h0000_4000, 32'h89AB_CDEF, 1, 32'h89AB_CDEF, 5'd12, 32'h210);
    endtask

    task automatic test_backpressure();
        step();
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(LdW, 1'b1, 1'b1, 5'd9, 32'h0000_0300, 32'h300);
        exp_q.push_back({1'b1, 5'd9, 32'hCAFE_BABE, 32'h300});
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_BABE;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            data_sram_data_ok = (i == 1);
            mid();
            total++;
            if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0 ||
                ms_to_ws_bus[63:32] !== 32'hCAFE_BABE) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got valid=%b allowin=%b result=%h, required 1 0 cafebabe",
                         i, ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]);
            end
            step();
        end
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        mid();
        total++;
        if (ms_allowin !== 1'b1) begin
            bad++; $display("FAIL bp_release: got allowin=%b, required 1", ms_allowin);
        end
        step();
        mid();
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++; $display("FAIL bp_single: got valid=%b, required 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] d;
        step();
        ws_allowin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 5'(i + 1);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(5'b0, 1'b0, (i != 3), d, 32'hA000_0000 + i, 32'h400 + 4 * i);
            exp_q.push_back({(i != 3), d, 32'hA000_0000 + i, 32'h400 + 4 * i});
            mid();
            total++;
            if (ms_allowin !== 1'b1) begin
                bad++; $display("FAIL b2b_allowin: cycle %0d got %b, required 1", i, ms_allowin);
            end
            if (i > 0) begin
                total++;
                if (ms_to_ws_valid !== 1'b1 ||
                    ms_to_ds_dest !== ((i - 1 == 3) ? 5'd0 : 5'(i))) begin
                    bad++;
                    $display("FAIL b2b_flow: cycle %0d got valid=%b dest=%0d, required 1 %0d",
                             i, ms_to_ws_valid, ms_to_ds_dest, (i - 1 == 3) ? 0 : i);
                end
            end
            step();
        end
        es_to_ms_valid = 1'b0;
        mid();
        step();
        mid();
        total++;
        if (exp_q.size() != 0 || ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got pending=%0d valid=%b, required 0 0",
                     exp_q.size(), ms_to_ws_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        step();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(LdW, 1'b1, 1'b1, 5'd10, 32'h0000_0500, 32'h500);
        step();
        es_to_ms_valid = 1'b0;
        mid();
        total++;
        if (ms_to_ds_stall !== 1'b1) begin
            bad++; $display("FAIL rml_wait: got stall=%b, required 1", ms_to_ds_stall);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (ms_allowin !== 1'b1 || ms_to_ds_stall !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL rml_async: got allowin=%b stall=%b valid=%b, required 1 0 0",
                     ms_allowin, ms_to_ds_stall, ms_to_ws_valid);
        end
        step();
        resetn = 1'b1;
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            mid();
            total++;
            if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ds_dest !== 5'd0) begin
                bad++;
                $display("FAIL rml_ignore: cycle %0d got valid=%b allowin=%b dest=%0d, required 0 1 0",
                         i, ms_to_ws_valid, ms_allowin, ms_to_ds_dest);
            end
            step();
            data_sram_data_ok = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
